// File: rtl/bp_gshare.sv
// rtl/bp_gshare.sv - gshare/bimodal branch predictor: PHT of saturating counters, speculative GHR with ROB repair
// Optional feature macro: BP_GSHARE_HIST_EN (XOR global history into the PHT index); undefined gives a pure bimodal predictor.
module bp_gshare #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 7,
    parameter int CNT_WIDTH  = 2,
    parameter int HIST_BITS  = 7
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  decoder_bp_en_in,
    input  logic [ADDR_WIDTH-1:0] decoder_bp_pc_in,
    input  logic [ADDR_WIDTH-1:0] decoder_bp_target_in,
    output logic                  bp_if_en_out,
    output logic [ADDR_WIDTH-1:0] bp_if_pc_out,
    output logic                  bp_instqueue_rst_out,
    output logic                  bp_dispatcher_taken_out,
    output logic [HIST_BITS-1:0]  bp_dispatcher_hist_out,
    input  logic                  rob_bp_en_in,
    input  logic [ADDR_WIDTH-1:0] rob_bp_pc_in,
    input  logic [HIST_BITS-1:0]  rob_bp_hist_in,
    input  logic                  rob_bp_taken_in,
    input  logic                  rob_bp_mispredict_in
);
    localparam int                   ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_MAX >> 1;

    logic [CNT_WIDTH-1:0]  pht [ENTRIES];
    logic [HIST_BITS-1:0]  ghr;
    logic [INDEX_BITS-1:0] pred_hist;
    logic [INDEX_BITS-1:0] upd_hist;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CNT_WIDTH-1:0]  upd_cnt;
    logic                  predicting;
    logic                  pred_taken;
    logic                  redirect;
    logic                  unused_pc_bits;

`ifdef BP_GSHARE_HIST_EN
    assign pred_hist = INDEX_BITS'(ghr);
    assign upd_hist  = INDEX_BITS'(rob_bp_hist_in);

    // A committing mispredict repairs history and wins over the wrong-path decoder shift.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ghr <= '0;
        end else if (rdy_in) begin
            if (rob_bp_en_in && rob_bp_mispredict_in) begin
                ghr <= (rob_bp_hist_in << 1) | HIST_BITS'(rob_bp_taken_in);
            end else if (decoder_bp_en_in) begin
                ghr <= (ghr << 1) | HIST_BITS'(pred_taken);
            end
        end
    end
`else
    logic unused_hist_inputs;

    assign ghr                = '0;
    assign pred_hist          = '0;
    assign upd_hist           = '0;
    assign unused_hist_inputs = ^{rob_bp_hist_in, rob_bp_mispredict_in};
`endif

    assign unused_pc_bits = ^{decoder_bp_pc_in, rob_bp_pc_in};

    assign pred_idx   = decoder_bp_pc_in[INDEX_BITS+1:2] ^ pred_hist;
    assign upd_idx    = rob_bp_pc_in[INDEX_BITS+1:2] ^ upd_hist;
    assign upd_cnt    = pht[upd_idx];
    assign pred_taken = pht[pred_idx][CNT_WIDTH-1];

    // Saturating counters; a same-cycle prediction reads the pre-update value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= CNT_INIT;
            end
        end else if (rdy_in && rob_bp_en_in) begin
            if (rob_bp_taken_in && upd_cnt != CNT_MAX) begin
                pht[upd_idx] <= upd_cnt + 1'b1;
            end else if (!rob_bp_taken_in && upd_cnt != '0) begin
                pht[upd_idx] <= upd_cnt - 1'b1;
            end
        end
    end

    assign predicting = rdy_in && decoder_bp_en_in && !rst_in;
    assign redirect   = predicting && pred_taken;

    assign bp_if_en_out            = redirect;
    assign bp_instqueue_rst_out    = redirect;
    assign bp_dispatcher_taken_out = redirect;
    assign bp_if_pc_out            = redirect ? decoder_bp_target_in : '0;
    assign bp_dispatcher_hist_out  = ghr;
endmodule

// File: tb/tb_bp_gshare.sv
// tb/tb_bp_gshare.sv - randomized self-checking bench for bp_gshare (2-bit and 3-bit counter instances)
module tb_bp_gshare;
`ifdef BP_GSHARE_HIST_EN
    localparam bit HIST_EN = 1'b1;
`else
    localparam bit HIST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        dec_en = 1'b0;
    logic [31:0] dec_pc = '0;
    logic [31:0] dec_tgt = '0;
    logic        rob_en = 1'b0;
    logic [31:0] rob_pc = '0;
    logic [6:0]  rob_hist = '0;
    logic        rob_taken = 1'b0;
    logic        rob_misp = 1'b0;

    logic        if_en_a, iq_rst_a, taken_a, if_en_b, iq_rst_b, taken_b;
    logic [31:0] if_pc_a, if_pc_b;
    logic [6:0]  hist_a, hist_b;

    int pht_a [128];
    int pht_b [128];
    int ghr_a, ghr_b;
    int n_checks = 0;
    int n_fail = 0;

    bp_gshare dut_a (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .decoder_bp_en_in(dec_en), .decoder_bp_pc_in(dec_pc), .decoder_bp_target_in(dec_tgt),
        .bp_if_en_out(if_en_a), .bp_if_pc_out(if_pc_a), .bp_instqueue_rst_out(iq_rst_a),
        .bp_dispatcher_taken_out(taken_a), .bp_dispatcher_hist_out(hist_a),
        .rob_bp_en_in(rob_en), .rob_bp_pc_in(rob_pc), .rob_bp_hist_in(rob_hist),
        .rob_bp_taken_in(rob_taken), .rob_bp_mispredict_in(rob_misp)
    );

    bp_gshare #(.CNT_WIDTH(3)) dut_b (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .decoder_bp_en_in(dec_en), .decoder_bp_pc_in(dec_pc), .decoder_bp_target_in(dec_tgt),
        .bp_if_en_out(if_en_b), .bp_if_pc_out(if_pc_b), .bp_instqueue_rst_out(iq_rst_b),
        .bp_dispatcher_taken_out(taken_b), .bp_dispatcher_hist_out(hist_b),
        .rob_bp_en_in(rob_en), .rob_bp_pc_in(rob_pc), .rob_bp_hist_in(rob_hist),
        .rob_bp_taken_in(rob_taken), .rob_bp_mispredict_in(rob_misp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int midx(input logic [31:0] pc, input int h);
        return (int'(pc[8:2]) ^ h) & 127;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            pht_a[i] = 1;
            pht_b[i] = 3;
        end
        ghr_a = 0;
        ghr_b = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model past the edge.
    task automatic cycle(input bit r, input bit de, input logic [31:0] dpc, input logic [31:0] dtgt,
                         input bit re, input logic [31:0] rpc, input logic [6:0] rh,
                         input bit rt, input bit rm);
        bit exp_a, exp_b;
        int ui, uh;
        rdy = r; dec_en = de; dec_pc = dpc; dec_tgt = dtgt;
        rob_en = re; rob_pc = rpc; rob_hist = rh; rob_taken = rt; rob_misp = rm;
        #3;
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (r && de) begin
            exp_a = pht_a[midx(dpc, ghr_a)] >= 2;
            exp_b = pht_b[midx(dpc, ghr_b)] >= 4;
        end
        check("taken_a", 32'(taken_a), 32'(exp_a));
        check("if_en_a", 32'(if_en_a), 32'(exp_a));
        check("iq_rst_a", 32'(iq_rst_a), 32'(exp_a));
        if (!(r && de) || exp_a) check("if_pc_a", if_pc_a, exp_a ? dtgt : 32'h0);
        check("hist_a", 32'(hist_a), 32'(ghr_a));
        check("taken_b", 32'(taken_b), 32'(exp_b));
        check("if_en_b", 32'(if_en_b), 32'(exp_b));
        check("hist_b", 32'(hist_b), 32'(ghr_b));
        if (r) begin
            if (re) begin
                uh = HIST_EN ? int'(rh) : 0;
                ui = midx(rpc, uh);
                pht_a[ui] = rt ? ((pht_a[ui] < 3) ? pht_a[ui] + 1 : 3) : ((pht_a[ui] > 0) ? pht_a[ui] - 1 : 0);
                pht_b[ui] = rt ? ((pht_b[ui] < 7) ? pht_b[ui] + 1 : 7) : ((pht_b[ui] > 0) ? pht_b[ui] - 1 : 0);
            end
            if (HIST_EN) begin
                if (re && rm) begin
                    ghr_a = ((int'(rh) << 1) | int'(rt)) & 127;
                    ghr_b = ghr_a;
                end else if (de) begin
                    ghr_a = ((ghr_a << 1) | int'(exp_a)) & 127;
                    ghr_b = ((ghr_b << 1) | int'(exp_b)) & 127;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        // Outputs must stay quiet while reset is held, even with a branch presented.
        #1;
        rdy = 1'b1; dec_en = 1'b1; dec_pc = 32'h100; dec_tgt = 32'h200;
        #2;
        check("rst_taken", 32'(taken_a), 32'h0);
        check("rst_if_en", 32'(if_en_a), 32'h0);
        check("rst_if_pc", if_pc_a, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cycle(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
        // Training on 0x100, then drain to zero with an extra saturating commit.
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 1, 32'h100, 0, 1, 0);
        cycle(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        cycle(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
        // Saturation: 10 taken then 3 not-taken on 0x40.
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 1, 32'h40, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 32'h40, 0, 0, 0);
        cycle(1, 1, 32'h40, 32'h80, 0, 0, 0, 0, 0);
        // Same-cycle predict and update of one entry sees the old counter.
        cycle(1, 1, 32'h100, 32'h300, 1, 32'h100, 0, 1, 0);
        cycle(1, 1, 32'h100, 32'h300, 0, 0, 0, 0, 0);
        // History shifts, then a repair overriding a simultaneous predict.
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h40, 32'h80, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h44, 32'h88, 1, 32'h40, 7'b0000001, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // History aliasing: GHR=3 maps PC 0x0C onto entry 0.
        cycle(1, 0, 0, 0, 1, 32'h8, 7'b0000001, 1, 1);
        cycle(1, 1, 32'h0C, 32'h500, 1, 32'h0C, 7'b0000011, 1, 0);
        cycle(1, 1, 32'h0C, 32'h500, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h00, 32'h504, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h0C, 32'h508, 0, 0, 0, 0, 0);
        // Stall: everything asserted with rdy low must leave state untouched.
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h40, 32'h80, 1, 32'h40, 7'h55, 0, 1);
        cycle(1, 1, 32'h40, 32'h80, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) != 0, 1'($urandom), 32'h1000 + 32'($urandom_range(0, 31) << 2),
                  $urandom, 1'($urandom), 32'h1000 + 32'($urandom_range(0, 31) << 2),
                  7'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
        end

        // Asynchronous reset between edges with a trained branch on the decoder.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 32'h2000, 0, 1, 0);
        cycle(1, 1, 32'h2004, 32'h700, 0, 0, 0, 0, 0);
        rdy = 1'b1; dec_en = 1'b1; dec_pc = 32'h2000; dec_tgt = 32'h900; rob_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_taken", 32'(taken_a), 32'h0);
        check("arst_if_en", 32'(if_en_a), 32'h0);
        check("arst_hist_a", 32'(hist_a), 32'h0);
        check("arst_hist_b", 32'(hist_b), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 1, 32'h2000, 32'h900, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
